// File: rtl/dtc_rr_sched_if.sv
// Requester/result handshake bundle between feature producers, the scheduler
// and the result consumer.
interface dtc_rr_sched_if #(
    parameter int NREQ   = 4,
    parameter int FEAT_W = 10,
    parameter int ID_W   = $clog2(NREQ)
);
    logic [NREQ-1:0]        req_valid;
    logic [NREQ*FEAT_W-1:0] req_feat;
    logic [NREQ-1:0]        req_ready;
    logic                   res_valid;
    logic                   res_class;
    logic [ID_W-1:0]        res_id;
    logic                   res_ready;

    modport master (
        output req_valid, req_feat, res_ready,
        input  req_ready, res_valid, res_class, res_id
    );

    modport slave (
        input  req_valid, req_feat, res_ready,
        output req_ready, res_valid, res_class, res_id
    );
endinterface

// File: rtl/dtc_rr_sched.sv
// Round-robin scheduler sharing one combinational decision-tree classifier
// among NREQ feature producers, with saturating per-class result counters.
//
// state  | meaning
// IDLE   | waiting for a request; grants round-robin and latches the feature
// EVAL   | feat_reg drives the classifier for a full settle cycle
// HOLD   | result presented, held until the consumer accepts it
module dtc_rr_sched #(
    parameter int NREQ   = 4,
    parameter int FEAT_W = 10,
    parameter int ID_W   = $clog2(NREQ),
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    dtc_rr_sched_if.slave     bus,
    output logic [FEAT_W-1:0] dt_inp,
    input  logic              dt_outp,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  cnt_c0,
    output logic [CNT_W-1:0]  cnt_c1
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EVAL = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;

    logic [1:0]        state;
    logic [FEAT_W-1:0] feat_reg;
    logic [ID_W-1:0]   id_reg;
    logic [ID_W-1:0]   last_grant;
    logic              gnt_found;
    logic [ID_W-1:0]   gnt_id;
    logic [FEAT_W-1:0] gnt_feat;
    logic              res_hs;

    // Search upward from last_grant+1 so the most recent winner has lowest priority.
    always_comb begin
        gnt_found = 1'b0;
        gnt_id    = '0;
        for (int k = 1; k <= NREQ; k++) begin
            int idx;
            idx = (int'(last_grant) + k) % NREQ;
            if (!gnt_found && bus.req_valid[idx]) begin
                gnt_found = 1'b1;
                gnt_id    = ID_W'(idx);
            end
        end
    end

    assign gnt_feat = bus.req_feat[int'(gnt_id)*FEAT_W +: FEAT_W];

    always_comb begin
        bus.req_ready = '0;
        if (!rst && state == S_IDLE && gnt_found)
            bus.req_ready = NREQ'(1) << gnt_id;
    end

    assign dt_inp = feat_reg;
    assign res_hs = bus.res_valid & bus.res_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_IDLE;
            feat_reg      <= '0;
            id_reg        <= '0;
            last_grant    <= ID_W'(NREQ - 1);
            bus.res_valid <= 1'b0;
            bus.res_class <= 1'b0;
            bus.res_id    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (gnt_found) begin
                        feat_reg   <= gnt_feat;
                        id_reg     <= gnt_id;
                        last_grant <= gnt_id;
                        state      <= S_EVAL;
                    end
                end
                S_EVAL: begin
                    bus.res_class <= dt_outp;
                    bus.res_id    <= id_reg;
                    bus.res_valid <= 1'b1;
                    state         <= S_HOLD;
                end
                S_HOLD: begin
                    if (bus.res_ready) begin
                        bus.res_valid <= 1'b0;
                        state         <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Clear takes priority over a same-edge increment; counts stick at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_c0 <= '0;
            cnt_c1 <= '0;
        end else if (cnt_clr) begin
            cnt_c0 <= '0;
            cnt_c1 <= '0;
        end else if (res_hs) begin
            if (bus.res_class) begin
                if (cnt_c1 != '1)
                    cnt_c1 <= cnt_c1 + CNT_W'(1);
            end else begin
                if (cnt_c0 != '1)
                    cnt_c0 <= cnt_c0 + CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_dtc_rr_sched.sv
// Directed bench for dtc_rr_sched: per-cycle vector table for fairness and a
// single request, then hand-written backpressure, saturation, sparse and reset sequences.
module tb_dtc_rr_sched;
    localparam int NREQ   = 4;
    localparam int FEAT_W = 10;
    localparam int ID_W   = 2;
    localparam int CNT_W  = 4;

    logic              clk;
    logic              rst;
    logic [FEAT_W-1:0] dt_inp;
    logic              dt_outp;
    logic              cnt_clr;
    logic [CNT_W-1:0]  cnt_c0;
    logic [CNT_W-1:0]  cnt_c1;

    int checks;
    int errors;

    dtc_rr_sched_if #(.NREQ(NREQ), .FEAT_W(FEAT_W), .ID_W(ID_W)) bus_if ();

    dtc_rr_sched #(.NREQ(NREQ), .FEAT_W(FEAT_W), .ID_W(ID_W), .CNT_W(CNT_W)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus_if.slave),
        .dt_inp  (dt_inp),
        .dt_outp (dt_outp),
        .cnt_clr (cnt_clr),
        .cnt_c0  (cnt_c0),
        .cnt_c1  (cnt_c1)
    );

    // Stand-in classifier: class 1 when feature bits 5 and 8 are both set.
    assign dt_outp = dt_inp[5] & dt_inp[8];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [NREQ-1:0]        vld;
        logic [NREQ*FEAT_W-1:0] feat;
        logic                   rdy;
        logic                   clr;
        logic [NREQ-1:0]        e_rr;
        logic                   e_rv;
        logic                   e_cls;
        logic [ID_W-1:0]        e_id;
        logic [FEAT_W-1:0]      e_dt;
        logic [CNT_W-1:0]       e_c0;
        logic [CNT_W-1:0]       e_c1;
    } vec_t;

    vec_t vec[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // One complete transaction from IDLE with res_ready held high.
    task automatic do_txn(input int id, input logic [FEAT_W-1:0] f, input logic clr, input logic cls);
        logic [NREQ*FEAT_W-1:0] fv;
        fv = '0;
        fv[id*FEAT_W +: FEAT_W] = f;
        bus_if.req_valid = NREQ'(1) << id;
        bus_if.req_feat  = fv;
        bus_if.res_ready = 1'b1;
        #1 chk("txn_req_ready", 64'(bus_if.req_ready), 64'(NREQ'(1) << id));
        next_cycle();
        bus_if.req_valid = '0;
        #1 chk("txn_dt_inp", 64'(dt_inp), 64'(f));
        next_cycle();
        cnt_clr = clr;
        #1;
        chk("txn_res_valid", 64'(bus_if.res_valid), 64'(1));
        chk("txn_res_class", 64'(bus_if.res_class), 64'(cls));
        chk("txn_res_id", 64'(bus_if.res_id), 64'(id));
        next_cycle();
        cnt_clr = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    localparam logic [NREQ*FEAT_W-1:0] F_FAIR = {10'h160, 10'h100, 10'h021, 10'h3FF};
    localparam logic [NREQ*FEAT_W-1:0] F_ONE  = {10'h000, 10'h000, 10'h000, 10'h120};

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        cnt_clr = 1'b0;
        bus_if.req_valid = 4'b1111;
        bus_if.req_feat  = F_FAIR;
        bus_if.res_ready = 1'b0;

        #1;
        chk("rst_req_ready", 64'(bus_if.req_ready), 64'(0));
        chk("rst_res_valid", 64'(bus_if.res_valid), 64'(0));
        chk("rst_res_class", 64'(bus_if.res_class), 64'(0));
        chk("rst_res_id", 64'(bus_if.res_id), 64'(0));
        chk("rst_dt_inp", 64'(dt_inp), 64'(0));
        chk("rst_cnt_c0", 64'(cnt_c0), 64'(0));
        chk("rst_cnt_c1", 64'(cnt_c1), 64'(0));
        #11;
        bus_if.req_valid = '0;
        rst = 1'b0;
        next_cycle();

        // Fairness: all valid, grants 0,1,2,3,0 every 3 cycles.
        //                 vld     feat    rdy  clr  rr       rv    cls   id     dt        c0    c1
        vec.push_back('{4'b1111, F_FAIR, 1'b1, 1'b0, 4'b0001, 1'b0, 1'b0, 2'd0, 10'h000, 4'd0, 4'd0});
        vec.push_back('{4'b1111, F_FAIR, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd0, 10'h3FF, 4'd0, 4'd0});
        vec.push_back('{4'b1111, F_FAIR, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b1, 2'd0, 10'h3FF, 4'd0, 4'd0});
        vec.push_back('{4'b1111, F_FAIR, 1'b1, 1'b0, 4'b0010, 1'b0, 1'b1, 2'd0, 10'h3FF, 4'd0, 4'd1});
        vec.push_back('{4'b1111, F_FAIR, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b1, 2'd0, 10'h021, 4'd0, 4'd1});
        vec.push_back('{4'b1111, F_FAIR, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b0, 2'd1, 10'h021, 4'd0, 4'd1});
        vec.push_back('{4'b1111, F_FAIR, 1'b1, 1'b0, 4'b0100, 1'b0, 1'b0, 2'd1, 10'h021, 4'd1, 4'd1});
        vec.push_back('{4'b1111, F_FAIR, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd1, 10'h100, 4'd1, 4'd1});
        vec.push_back('{4'b1111, F_FAIR, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b0, 2'd2, 10'h100, 4'd1, 4'd1});
        vec.push_back('{4'b1111, F_FAIR, 1'b1, 1'b0, 4'b1000, 1'b0, 1'b0, 2'd2, 10'h100, 4'd2, 4'd1});
        vec.push_back('{4'b1111, F_FAIR, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd2, 10'h160, 4'd2, 4'd1});
        vec.push_back('{4'b1111, F_FAIR, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b1, 2'd3, 10'h160, 4'd2, 4'd1});
        vec.push_back('{4'b1111, F_FAIR, 1'b1, 1'b0, 4'b0001, 1'b0, 1'b1, 2'd3, 10'h160, 4'd2, 4'd2});
        vec.push_back('{4'b1111, F_FAIR, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b1, 2'd3, 10'h3FF, 4'd2, 4'd2});
        vec.push_back('{4'b1111, F_FAIR, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b1, 2'd0, 10'h3FF, 4'd2, 4'd2});
        // Single request from requester 0 with 10'h120 (class 1).
        vec.push_back('{4'b0001, F_ONE,  1'b1, 1'b0, 4'b0001, 1'b0, 1'b1, 2'd0, 10'h3FF, 4'd2, 4'd3});
        vec.push_back('{4'b0000, F_ONE,  1'b1, 1'b0, 4'b0000, 1'b0, 1'b1, 2'd0, 10'h120, 4'd2, 4'd3});
        vec.push_back('{4'b0000, F_ONE,  1'b1, 1'b0, 4'b0000, 1'b1, 1'b1, 2'd0, 10'h120, 4'd2, 4'd3});
        vec.push_back('{4'b0000, F_ONE,  1'b1, 1'b0, 4'b0000, 1'b0, 1'b1, 2'd0, 10'h120, 4'd2, 4'd4});

        for (int i = 0; i < vec.size(); i++) begin
            bus_if.req_valid = vec[i].vld;
            bus_if.req_feat  = vec[i].feat;
            bus_if.res_ready = vec[i].rdy;
            cnt_clr          = vec[i].clr;
            #1;
            chk($sformatf("vec%0d_req_ready", i), 64'(bus_if.req_ready), 64'(vec[i].e_rr));
            chk($sformatf("vec%0d_res_valid", i), 64'(bus_if.res_valid), 64'(vec[i].e_rv));
            chk($sformatf("vec%0d_res_class", i), 64'(bus_if.res_class), 64'(vec[i].e_cls));
            chk($sformatf("vec%0d_res_id", i), 64'(bus_if.res_id), 64'(vec[i].e_id));
            chk($sformatf("vec%0d_dt_inp", i), 64'(dt_inp), 64'(vec[i].e_dt));
            chk($sformatf("vec%0d_cnt_c0", i), 64'(cnt_c0), 64'(vec[i].e_c0));
            chk($sformatf("vec%0d_cnt_c1", i), 64'(cnt_c1), 64'(vec[i].e_c1));
            next_cycle();
        end

        // Backpressure: requester 2 with 10'h000, consumer stalls 5 cycles.
        bus_if.req_valid = 4'b0100;
        bus_if.req_feat  = {10'h3FF, 10'h000, 10'h3FF, 10'h3FF};
        bus_if.res_ready = 1'b0;
        #1 chk("bp_req_ready", 64'(bus_if.req_ready), 64'(4'b0100));
        next_cycle();
        bus_if.req_valid = 4'b1111;
        #1 chk("bp_dt_inp", 64'(dt_inp), 64'(0));
        next_cycle();
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_res_valid", 64'(bus_if.res_valid), 64'(1));
            chk("bp_res_class", 64'(bus_if.res_class), 64'(0));
            chk("bp_res_id", 64'(bus_if.res_id), 64'(2));
            chk("bp_req_ready", 64'(bus_if.req_ready), 64'(0));
            chk("bp_cnt_c0", 64'(cnt_c0), 64'(2));
            next_cycle();
        end
        bus_if.res_ready = 1'b1;
        bus_if.req_valid = '0;
        #1 chk("bp_last_valid", 64'(bus_if.res_valid), 64'(1));
        next_cycle();
        chk("bp_done_valid", 64'(bus_if.res_valid), 64'(0));
        chk("bp_cnt_c0_inc", 64'(cnt_c0), 64'(3));
        chk("bp_cnt_c1_same", 64'(cnt_c1), 64'(4));

        // Saturation: cnt_c1 4 -> 15, then one more stays at 15.
        for (int i = 0; i < 11; i++) do_txn(0, 10'h120, 1'b0, 1'b1);
        chk("sat_cnt_c1_full", 64'(cnt_c1), 64'(15));
        do_txn(0, 10'h120, 1'b0, 1'b1);
        chk("sat_cnt_c1_hold", 64'(cnt_c1), 64'(15));
        chk("sat_cnt_c0", 64'(cnt_c0), 64'(3));
        do_txn(0, 10'h120, 1'b1, 1'b1);
        chk("clr_hs_cnt_c1", 64'(cnt_c1), 64'(0));
        chk("clr_hs_cnt_c0", 64'(cnt_c0), 64'(0));

        // Sparse: requester 3 alone, granted back-to-back with no lost cycle.
        do_txn(3, 10'h160, 1'b0, 1'b1);
        do_txn(3, 10'h160, 1'b0, 1'b1);
        chk("sparse_cnt_c1", 64'(cnt_c1), 64'(2));

        // Reset while a result from requester 2 is held.
        bus_if.req_valid = 4'b0100;
        bus_if.req_feat  = {10'h000, 10'h3FF, 10'h000, 10'h000};
        bus_if.res_ready = 1'b0;
        #1 chk("rmid_req_ready", 64'(bus_if.req_ready), 64'(4'b0100));
        next_cycle();
        bus_if.req_valid = '0;
        next_cycle();
        #1 chk("rmid_hold_valid", 64'(bus_if.res_valid), 64'(1));
        #1;
        rst = 1'b1;
        bus_if.req_valid = 4'b1010;
        bus_if.req_feat  = {10'h021, 10'h000, 10'h120, 10'h000};
        #1;
        chk("rmid_res_valid", 64'(bus_if.res_valid), 64'(0));
        chk("rmid_cnt_c0", 64'(cnt_c0), 64'(0));
        chk("rmid_cnt_c1", 64'(cnt_c1), 64'(0));
        chk("rmid_req_ready", 64'(bus_if.req_ready), 64'(0));
        chk("rmid_dt_inp", 64'(dt_inp), 64'(0));
        chk("rmid_res_id", 64'(bus_if.res_id), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        #1 chk("rpost_req_ready", 64'(bus_if.req_ready), 64'(4'b0010));
        next_cycle();
        chk("rpost_dt_inp", 64'(dt_inp), 64'(10'h120));
        chk("rpost_res_valid", 64'(bus_if.res_valid), 64'(0));
        chk("rpost_req_ready_eval", 64'(bus_if.req_ready), 64'(0));
        bus_if.req_valid = '0;
        bus_if.res_ready = 1'b1;
        next_cycle();
        chk("rpost_hold_valid", 64'(bus_if.res_valid), 64'(1));
        chk("rpost_hold_id", 64'(bus_if.res_id), 64'(1));
        chk("rpost_hold_class", 64'(bus_if.res_class), 64'(1));
        next_cycle();
        chk("rpost_cnt_c1", 64'(cnt_c1), 64'(1));
        chk("rpost_cnt_c0", 64'(cnt_c0), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
